// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the I-cache fill port, the D-cache miss/writeback
// port and the shared line-wide backing-memory port of mem_port_arbiter.
//   slave  : arbiter side (takes requests and mem_rdata, drives readies, read data, strobes, busy)
//   master : client side (caches and memory model together, the mirror of slave)
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned LINE_WIDTH = 64
);
   // I-cache fill port
   logic                  i_req;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic                  i_flush;
   logic                  i_ready;
   logic [LINE_WIDTH-1:0] i_rdata;
   // D-cache miss / writeback port
   logic                  d_req;
   logic                  d_we;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic [LINE_WIDTH-1:0] d_wdata;
   logic                  d_ready;
   logic [LINE_WIDTH-1:0] d_rdata;
   // backing-memory port
   logic                  mem_read;
   logic                  mem_write;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [LINE_WIDTH-1:0] mem_wdata;
   logic [LINE_WIDTH-1:0] mem_rdata;
   // status
   logic                  busy;

   modport slave (
      input  i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output i_ready, i_rdata, d_ready, d_rdata,
      output mem_read, mem_write, mem_addr, mem_wdata, busy
   );

   modport master (
      output i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  i_ready, i_rdata, d_ready, d_rdata,
      input  mem_read, mem_write, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one line-wide memory port between the I-cache fill
// path and the D-cache miss/writeback path. Each transfer holds its strobe for
// LATENCY cycles; D has priority, but after STARVE_LIMIT consecutive D grants
// with I waiting, I is forced. An in-flight I fill can be abandoned by i_flush.
// Ports:
//   clk      clock
//   reset_n  synchronous active-low reset
//   bus      mem_port_arbiter_if.slave (I port, D port, memory port, busy)
module mem_port_arbiter #(
   parameter int unsigned ADDR_WIDTH   = 16,
   parameter int unsigned LINE_WIDTH   = 64,
   parameter int unsigned LATENCY      = 2,
   parameter int unsigned STARVE_LIMIT = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   mem_port_arbiter_if.slave  bus
);

   localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int unsigned STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);
   localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [STV_W-1:0]      starve_q, starve_d;
   logic                  abort_q, abort_d;
   logic                  i_ready_q, i_ready_d;
   logic                  d_ready_q, d_ready_d;
   logic [LINE_WIDTH-1:0] i_rdata_q, i_rdata_d;
   logic [LINE_WIDTH-1:0] d_rdata_q, d_rdata_d;
   logic                  mem_read_q, mem_read_d;
   logic                  mem_write_q, mem_write_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [LINE_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic                  busy_q;

   logic i_elig, d_elig, grant_i, grant_d;

   // A port whose ready is high this cycle is still showing the old request.
   assign i_elig  = bus.i_req && !i_ready_q && !bus.i_flush;
   assign d_elig  = bus.d_req && !d_ready_q;
   assign grant_d = (state_q == IDLE) && d_elig && !(i_elig && (starve_q == STV_MAX));
   assign grant_i = (state_q == IDLE) && i_elig && !grant_d;

   // State and output registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         starve_q    <= '0;
         abort_q     <= 1'b0;
         i_ready_q   <= 1'b0;
         d_ready_q   <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         starve_q    <= starve_d;
         abort_q     <= abort_d;
         i_ready_q   <= i_ready_d;
         d_ready_q   <= d_ready_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= (state_d != IDLE);
      end
   end

   // Next-state, transfer sequencing and starvation tracking
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      starve_d    = starve_q;
      abort_d     = abort_q;
      i_ready_d   = 1'b0;
      d_ready_d   = 1'b0;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      case (state_q)
         IDLE: begin
            abort_d = 1'b0;
            if (grant_d) begin
               state_d    = BUSY_D;
               cnt_d      = '0;
               mem_addr_d = bus.d_addr;
               if (bus.d_we) begin
                  mem_write_d = 1'b1;
                  mem_wdata_d = bus.d_wdata;
               end else begin
                  mem_read_d = 1'b1;
               end
            end else if (grant_i) begin
               state_d    = BUSY_I;
               cnt_d      = '0;
               mem_addr_d = bus.i_addr;
               mem_read_d = 1'b1;
            end
         end

         BUSY_I: begin
            if (bus.i_flush) begin
               abort_d = 1'b1;
            end
            if (cnt_q == CNT_LAST) begin
               state_d    = IDLE;
               mem_read_d = 1'b0;
               abort_d    = 1'b0;
               // A flush in the final strobe cycle also suppresses delivery.
               if (!(abort_q || bus.i_flush)) begin
                  i_ready_d = 1'b1;
                  i_rdata_d = bus.mem_rdata;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         BUSY_D: begin
            if (cnt_q == CNT_LAST) begin
               state_d     = IDLE;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               d_ready_d   = 1'b1;
               if (!mem_write_q) begin
                  d_rdata_d = bus.mem_rdata;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d     = IDLE;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            abort_d     = 1'b0;
         end
      endcase

      // D grants made while I waits count toward forcing an I grant.
      if (!bus.i_req || grant_i) begin
         starve_d = '0;
      end else if (grant_d && (starve_q != STV_MAX)) begin
         starve_d = starve_q + 1'b1;
      end
   end

   assign bus.i_ready   = i_ready_q;
   assign bus.i_rdata   = i_rdata_q;
   assign bus.d_ready   = d_ready_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.mem_read  = mem_read_q;
   assign bus.mem_write = mem_write_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a scoreboard. Expected read data
// is queued per port when a transfer is requested; a negedge monitor pops and
// compares on every ready pulse and flags pulses that nothing expected.
module tb_mem_port_arbiter;

   localparam int unsigned AW  = 16;
   localparam int unsigned LW  = 64;
   localparam int unsigned LAT = 2;
   localparam int unsigned SL  = 2;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

   mem_port_arbiter #(
      .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .LATENCY(LAT), .STARVE_LIMIT(SL)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [LW-1:0] exp_i_q[$];
   logic [LW-1:0] exp_d_q[$];
   logic [LW-1:0] i_model = '0;
   logic [LW-1:0] d_model = '0;
   int unsigned strobe_age = 0;

   function automatic logic [LW-1:0] line_for(input logic [AW-1:0] a);
      if (a == 16'h0040) return 64'h1111_2222_3333_4444;
      return {a, ~a, a ^ 16'h5A5A, 16'hC0DE};
   endfunction

   // Memory model: data is valid only in the last strobe cycle.
   always @(posedge clk) strobe_age <= (bus.mem_read || bus.mem_write) ? strobe_age + 1 : 0;
   always_comb begin
      if ((bus.mem_read || bus.mem_write) && strobe_age == LAT - 1)
         bus.mem_rdata = line_for(bus.mem_addr);
      else
         bus.mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
   end

   task automatic check1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkv(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check1({tag, "_i_ready"}, bus.i_ready, 1'b0);
      check1({tag, "_d_ready"}, bus.d_ready, 1'b0);
      checkv({tag, "_i_rdata"}, bus.i_rdata, '0);
      checkv({tag, "_d_rdata"}, bus.d_rdata, '0);
      check1({tag, "_mem_read"}, bus.mem_read, 1'b0);
      check1({tag, "_mem_write"}, bus.mem_write, 1'b0);
      checkv({tag, "_mem_addr"}, LW'(bus.mem_addr), '0);
      checkv({tag, "_mem_wdata"}, bus.mem_wdata, '0);
      check1({tag, "_busy"}, bus.busy, 1'b0);
   endtask

   task automatic check_strobe(input string tag, input logic rd, input logic wr,
                               input logic [AW-1:0] addr);
      check1({tag, "_mem_read"}, bus.mem_read, rd);
      check1({tag, "_mem_write"}, bus.mem_write, wr);
      checkv({tag, "_mem_addr"}, LW'(bus.mem_addr), LW'(addr));
      check1({tag, "_busy"}, bus.busy, 1'b1);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (reset_n) begin
         if (bus.i_ready) begin
            if (exp_i_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL i_ready_unexpected: got i_ready=1 expected no pulse at %0t", $time);
            end else begin
               checkv("i_rdata_sb", bus.i_rdata, exp_i_q.pop_front());
            end
         end
         if (bus.d_ready) begin
            if (exp_d_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL d_ready_unexpected: got d_ready=1 expected no pulse at %0t", $time);
            end else begin
               checkv("d_rdata_sb", bus.d_rdata, exp_d_q.pop_front());
            end
         end
         if (bus.i_ready && bus.d_ready) begin
            n_cmp++; n_err++;
            $display("FAIL both_ready: got i_ready=1 d_ready=1 expected at most one at %0t", $time);
         end
         if (bus.mem_read && bus.mem_write) begin
            n_cmp++; n_err++;
            $display("FAIL both_strobes: got read=1 write=1 expected at most one at %0t", $time);
         end
      end
   end

   initial begin
      bus.i_req = 1'b0; bus.i_addr = '0; bus.i_flush = 1'b0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_zero("rst");
      reset_n = 1'b1;
      next_cycle();

      // 1 + 6: single I fill, request held through its ready cycle
      bus.i_req = 1'b1; bus.i_addr = 16'h0040;
      i_model = 64'h1111_2222_3333_4444; exp_i_q.push_back(i_model);
      next_cycle(); check_strobe("t1_c1", 1'b1, 1'b0, 16'h0040);
      next_cycle(); check_strobe("t1_c2", 1'b1, 1'b0, 16'h0040);
      next_cycle();
      check1("t1_i_ready", bus.i_ready, 1'b1);
      checkv("t1_i_rdata", bus.i_rdata, 64'h1111_2222_3333_4444);
      check1("t1_busy_c3", bus.busy, 1'b0);
      check1("t1_read_c3", bus.mem_read, 1'b0);
      next_cycle(); bus.i_req = 1'b0;
      check1("t6_busy_c4", bus.busy, 1'b0);
      check1("t6_read_c4", bus.mem_read, 1'b0);
      check1("t6_ready_c4", bus.i_ready, 1'b0);
      next_cycle();
      check1("t6_busy_c5", bus.busy, 1'b0);

      // 2: simultaneous requests, D write wins, I follows back-to-back
      bus.i_req = 1'b1; bus.i_addr = 16'h0100;
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0080;
      bus.d_wdata = 64'hAAAA_BBBB_CCCC_DDDD;
      exp_d_q.push_back(d_model);
      i_model = line_for(16'h0100); exp_i_q.push_back(i_model);
      next_cycle(); check_strobe("t2_c1", 1'b0, 1'b1, 16'h0080);
      checkv("t2_wdata", bus.mem_wdata, 64'hAAAA_BBBB_CCCC_DDDD);
      next_cycle(); check_strobe("t2_c2", 1'b0, 1'b1, 16'h0080);
      next_cycle(); bus.d_req = 1'b0; bus.d_we = 1'b0;
      check1("t2_d_ready", bus.d_ready, 1'b1);
      checkv("t2_d_rdata_kept", bus.d_rdata, d_model);
      check1("t2_write_c3", bus.mem_write, 1'b0);
      next_cycle(); check_strobe("t2_c4", 1'b1, 1'b0, 16'h0100);
      next_cycle(); check_strobe("t2_c5", 1'b1, 1'b0, 16'h0100);
      next_cycle(); bus.i_req = 1'b0;
      check1("t2_i_ready", bus.i_ready, 1'b1);
      next_cycle();

      // 3: starvation; flush in each D ready cycle keeps I out of the free arbitration
      bus.i_req = 1'b1; bus.i_addr = 16'h0200;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0300;
      d_model = line_for(16'h0300); exp_d_q.push_back(d_model);
      next_cycle(); check_strobe("t3_c1", 1'b1, 1'b0, 16'h0300);
      next_cycle();
      next_cycle(); bus.i_flush = 1'b1; bus.d_addr = 16'h0310;
      check1("t3_d_ready1", bus.d_ready, 1'b1);
      d_model = line_for(16'h0310); exp_d_q.push_back(d_model);
      next_cycle(); bus.i_flush = 1'b0;
      check1("t3_idle_c4", bus.busy, 1'b0);
      next_cycle(); check_strobe("t3_c5", 1'b1, 1'b0, 16'h0310);
      next_cycle();
      next_cycle(); bus.i_flush = 1'b1; bus.d_addr = 16'h0320;
      check1("t3_d_ready2", bus.d_ready, 1'b1);
      next_cycle(); bus.i_flush = 1'b0;
      check1("t3_idle_c8", bus.busy, 1'b0);
      i_model = line_for(16'h0200); exp_i_q.push_back(i_model);
      next_cycle(); check_strobe("t3_c9_forced_i", 1'b1, 1'b0, 16'h0200);
      next_cycle();
      next_cycle(); bus.i_req = 1'b0;
      check1("t3_i_ready", bus.i_ready, 1'b1);
      d_model = line_for(16'h0320); exp_d_q.push_back(d_model);
      next_cycle(); check_strobe("t3_c12", 1'b1, 1'b0, 16'h0320);
      next_cycle();
      next_cycle(); bus.d_req = 1'b0;
      check1("t3_d_ready3", bus.d_ready, 1'b1);
      next_cycle();

      // 4: flush in the last strobe cycle, pending D granted right after
      bus.i_req = 1'b1; bus.i_addr = 16'h0400;
      next_cycle(); check_strobe("t4_c1", 1'b1, 1'b0, 16'h0400);
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0500;
      d_model = line_for(16'h0500); exp_d_q.push_back(d_model);
      next_cycle(); check_strobe("t4_c2", 1'b1, 1'b0, 16'h0400);
      bus.i_flush = 1'b1; bus.i_req = 1'b0;
      next_cycle(); bus.i_flush = 1'b0;
      check1("t4_no_i_ready", bus.i_ready, 1'b0);
      checkv("t4_i_rdata_kept", bus.i_rdata, i_model);
      check1("t4_read_c3", bus.mem_read, 1'b0);
      check1("t4_busy_c3", bus.busy, 1'b0);
      next_cycle(); check_strobe("t4_c4", 1'b1, 1'b0, 16'h0500);
      next_cycle();
      next_cycle(); bus.d_req = 1'b0;
      check1("t4_d_ready", bus.d_ready, 1'b1);
      next_cycle();

      // 4b: flush pulse in the first strobe cycle must be remembered
      bus.i_req = 1'b1; bus.i_addr = 16'h0440;
      next_cycle(); bus.i_flush = 1'b1; bus.i_req = 1'b0;
      next_cycle(); bus.i_flush = 1'b0;
      check_strobe("t4b_c2", 1'b1, 1'b0, 16'h0440);
      next_cycle();
      check1("t4b_no_i_ready", bus.i_ready, 1'b0);
      checkv("t4b_i_rdata_kept", bus.i_rdata, i_model);
      next_cycle();

      // 5: reset in the middle of a D read, then a fresh I fill
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0600;
      next_cycle(); check_strobe("t5_c1", 1'b1, 1'b0, 16'h0600);
      next_cycle(); reset_n = 1'b0; bus.d_req = 1'b0;
      next_cycle();
      check_zero("t5_rst");
      reset_n = 1'b1;
      d_model = '0;
      bus.i_req = 1'b1; bus.i_addr = 16'h0700;
      i_model = line_for(16'h0700); exp_i_q.push_back(i_model);
      next_cycle(); check_strobe("t5_c4", 1'b1, 1'b0, 16'h0700);
      check1("t5_no_d_ready", bus.d_ready, 1'b0);
      next_cycle();
      next_cycle(); bus.i_req = 1'b0;
      check1("t5_i_ready", bus.i_ready, 1'b1);
      checkv("t5_d_rdata_zero", bus.d_rdata, d_model);

      // Every expected pulse must have arrived
      repeat (4) next_cycle();
      checkv("i_queue_drained", LW'(exp_i_q.size()), '0);
      checkv("d_queue_drained", LW'(exp_d_q.size()), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
